ps2_keyboard_tx: RTL and testbench

- Device-side PS/2 keyboard emulator: accepts ASCII characters and produces the matching scancode byte sequence (make, F0, break) as PS/2 frames on ps2_clk/ps2_data.
- Sits upstream of the PS/2 receiver and keyboard display path in simulation and loopback builds; it is the transmitter end of the scancode link those blocks consume.

---
 rtl/ps2_keyboard_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_tx.sv
// rtl/ps2_keyboard_tx.sv - device-side PS/2 keyboard emulator: ASCII in, set-2 make/F0/break frames out.
// Optional PS2TX_BYTE_TAP_EN adds tap_data/tap_flag reporting each byte as its stop bit completes.
module ps2_keyboard_tx #(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
`ifdef PS2TX_BYTE_TAP_EN
  output logic [7:0] tap_data,
  output logic       tap_flag,
`endif
  output logic       unsupported
);

  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_HI, S_BIT_LO, S_GAP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_idx;
  logic [10:0]     r_frame;
  logic [7:0]      r_code;
  logic            r_shift;
  logic [2:0]      r_bidx;
  logic            r_unsupported;
  logic [9:0]      w_map;
  logic [7:0]      w_byte;
  logic            w_accept;
  logic            w_half_done;
  logic            w_gap_done;
  logic            w_last_byte;

  // Result is {mapped, shifted, set-2 code}; uppercase folds onto lowercase codes.
  function automatic logic [9:0] map_ascii(input logic [7:0] c);
    logic [7:0] lc;
    logic       sh;
    map_ascii = '0;
    sh = (c >= 8'h41) && (c <= 8'h5A);
    lc = sh ? (c | 8'h20) : c;
    case (lc)
      8'h30: map_ascii = {2'b10, 8'h45};
      8'h31: map_ascii = {2'b10, 8'h16};
      8'h32: map_ascii = {2'b10, 8'h1E};
      8'h33: map_ascii = {2'b10, 8'h26};
      8'h34: map_ascii = {2'b10, 8'h25};
      8'h35: map_ascii = {2'b10, 8'h2E};
      8'h36: map_ascii = {2'b10, 8'h36};
      8'h37: map_ascii = {2'b10, 8'h3D};
      8'h38: map_ascii = {2'b10, 8'h3E};
      8'h39: map_ascii = {2'b10, 8'h46};
      8'h61: map_ascii = {2'b10, 8'h1C};
      8'h62: map_ascii = {2'b10, 8'h32};
      8'h63: map_ascii = {2'b10, 8'h21};
      8'h64: map_ascii = {2'b10, 8'h23};
      8'h65: map_ascii = {2'b10, 8'h24};
      8'h66: map_ascii = {2'b10, 8'h2B};
      8'h67: map_ascii = {2'b10, 8'h34};
      8'h68: map_ascii = {2'b10, 8'h33};
      8'h69: map_ascii = {2'b10, 8'h43};
      8'h6A: map_ascii = {2'b10, 8'h3B};
      8'h6B: map_ascii = {2'b10, 8'h42};
      8'h6C: map_ascii = {2'b10, 8'h4B};
      8'h6D: map_ascii = {2'b10, 8'h3A};
      8'h6E: map_ascii = {2'b10, 8'h31};
      8'h6F: map_ascii = {2'b10, 8'h44};
      8'h70: map_ascii = {2'b10, 8'h4D};
      8'h71: map_ascii = {2'b10, 8'h15};
      8'h72: map_ascii = {2'b10, 8'h2D};
      8'h73: map_ascii = {2'b10, 8'h1B};
      8'h74: map_ascii = {2'b10, 8'h2C};
      8'h75: map_ascii = {2'b10, 8'h3C};
      8'h76: map_ascii = {2'b10, 8'h2A};
      8'h77: map_ascii = {2'b10, 8'h1D};
      8'h78: map_ascii = {2'b10, 8'h22};
      8'h79: map_ascii = {2'b10, 8'h35};
      8'h7A: map_ascii = {2'b10, 8'h1A};
      default: map_ascii = '0;
    endcase
    if (map_ascii[9]) map_ascii[8] = sh;
  endfunction

  function automatic logic [7:0] seq_byte(input logic [2:0] i, input logic sh, input logic [7:0] code);
    if (sh) begin
      case (i)
        3'd0:    seq_byte = 8'h12;
        3'd1:    seq_byte = code;
        3'd2:    seq_byte = 8'hF0;
        3'd3:    seq_byte = code;
        3'd4:    seq_byte = 8'hF0;
        default: seq_byte = 8'h12;
      endcase
    end else begin
      seq_byte = (i == 3'd1) ? 8'hF0 : code;
    end
  endfunction

  assign w_map       = map_ascii(ascii_in);
  assign w_byte      = seq_byte(r_bidx, r_shift, r_code);
  assign w_accept    = (r_state == S_IDLE) && ascii_valid;
  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_gap_done  = (r_cnt == GAP_LAST);
  assign w_last_byte = (r_bidx == (r_shift ? 3'd5 : 3'd2));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_map[9]) w_next = S_LOAD;
      S_LOAD:   w_next = S_BIT_HI;
      S_BIT_HI: if (w_half_done) w_next = S_BIT_LO;
      S_BIT_LO: if (w_half_done) w_next = (r_idx == 4'd10) ? S_GAP : S_BIT_HI;
      S_GAP:    if (w_gap_done) w_next = w_last_byte ? S_IDLE : S_LOAD;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frame       <= '1;
      r_code        <= '0;
      r_shift       <= 1'b0;
      r_bidx        <= '0;
      r_unsupported <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_unsupported <= w_accept && !w_map[9];
      // Counter restarts on every state entry, so it never wraps inside a state.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
      if (w_accept && w_map[9]) begin
        r_code  <= w_map[7:0];
        r_shift <= w_map[8];
        r_bidx  <= '0;
      end
      if (r_state == S_LOAD) begin
        r_frame <= {1'b1, ~^w_byte, w_byte, 1'b0};
        r_idx   <= '0;
      end
      if (r_state == S_BIT_LO && w_half_done && r_idx != 4'd10) r_idx <= r_idx + 1'b1;
      if (r_state == S_GAP && w_gap_done && !w_last_byte) r_bidx <= r_bidx + 1'b1;
    end
  end

  assign ascii_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign unsupported = r_unsupported;
  assign ps2_clk     = (r_state != S_BIT_LO);
  assign ps2_data    = (r_state == S_BIT_HI || r_state == S_BIT_LO) ? r_frame[r_idx] : 1'b1;

`ifdef PS2TX_BYTE_TAP_EN
  logic [7:0] r_tap_data;
  logic       r_tap_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_data <= '0;
      r_tap_flag <= 1'b0;
    end else begin
      r_tap_flag <= (r_state == S_BIT_LO) && w_half_done && (r_idx == 4'd10);
      if ((r_state == S_BIT_LO) && w_half_done && (r_idx == 4'd10)) r_tap_data <= r_frame[8:1];
    end
  end

  assign tap_data = r_tap_data;
  assign tap_flag = r_tap_flag;
`endif

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb/tb_ps2_keyboard_tx.sv - self-checking bench for ps2_keyboard_tx (table, random and corner sequences).
module tb_ps2_keyboard_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int BYTE_CYC   = 1 + 22 * CLK_DIV + GAP_CYCLES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       ascii_valid = 1'b0;
  logic       ascii_ready, ps2_clk, ps2_data, busy, unsupported;
`ifdef PS2TX_BYTE_TAP_EN
  logic [7:0] tap_data;
  logic       tap_flag;
`endif

  always #5 clk = ~clk;

  ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
`ifdef PS2TX_BYTE_TAP_EN
    .tap_data(tap_data), .tap_flag(tap_flag),
`endif
    .unsupported(unsupported)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  bit       rx_bits[$];
  int       falls = 0;
  time      t_first_fall = 0;
  always @(negedge ps2_clk) if (rst_n === 1'b1) begin
    if (falls == 0) t_first_fall = $time;
    rx_bits.push_back(ps2_data);
    falls++;
  end

`ifdef PS2TX_BYTE_TAP_EN
  logic [7:0] tap_q[$];
  always @(negedge clk) if (tap_flag === 1'b1) tap_q.push_back(tap_data);
`endif

  // Reference model: character classes to set-2 codes, sequence built as a byte list.
  logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] exp_q[$];

  task automatic build_expected(input logic [7:0] c);
    logic [7:0] code;
    exp_q.delete();
    if (c >= 8'h30 && c <= 8'h39) begin
      code = digit_codes[c - 8'h30];
      exp_q = '{code, 8'hF0, code};
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      code = letter_codes[c - 8'h61];
      exp_q = '{code, 8'hF0, code};
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      code = letter_codes[c - 8'h41];
      exp_q = '{8'h12, code, 8'hF0, code, 8'hF0, 8'h12};
    end
  endtask

  task automatic check_frames(input string tag);
    logic [7:0] d;
    bit         fr_ok;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (rx_bits.size() >= 11 * (k + 1)) begin
        for (int i = 0; i < 8; i++) d[i] = rx_bits[11 * k + 1 + i];
        fr_ok = (rx_bits[11 * k] == 1'b0) && (rx_bits[11 * k + 10] == 1'b1) &&
                (($countones(d) + int'(rx_bits[11 * k + 9])) % 2 == 1);
        check($sformatf("%s byte%0d", tag, k), d, exp_q[k]);
        check($sformatf("%s framing%0d", tag, k), fr_ok, 1);
      end else begin
        check($sformatf("%s missing_frame%0d", tag, k), rx_bits.size(), 11 * (k + 1));
      end
    end
  endtask

  task automatic run_char(input logic [7:0] c, input string tag);
    int  cnt;
    time t_hs;
    bit  mapped;
    mapped = (exp_q.size() != 0);
    rx_bits.delete();
    falls = 0;
    t_first_fall = 0;
`ifdef PS2TX_BYTE_TAP_EN
    tap_q.delete();
`endif
    cnt = 0;
    while (ascii_ready !== 1'b1 && cnt < 5000) begin @(negedge clk); cnt++; end
    @(negedge clk);
    ascii_in = c;
    ascii_valid = 1'b1;
    @(posedge clk);
    t_hs = $time;
    #1 ascii_valid = 1'b0;
    check({tag, " unsupported_pulse"}, unsupported, !mapped);
    cnt = 0;
    while (busy === 1'b1 && cnt < 6 * BYTE_CYC + 50) begin cnt++; @(posedge clk); #1; end
    check({tag, " busy_cycles"}, cnt, exp_q.size() * BYTE_CYC);
    check({tag, " ready_after"}, ascii_ready, 1);
    @(posedge clk); #1;
    check({tag, " unsupported_clear"}, unsupported, 0);
    check({tag, " idle_lines"}, {ps2_clk, ps2_data}, 2'b11);
    check({tag, " fall_count"}, falls, 11 * exp_q.size());
    if (mapped) check({tag, " first_fall"}, (t_first_fall - t_hs) / 10, CLK_DIV + 1);
    check_frames(tag);
`ifdef PS2TX_BYTE_TAP_EN
    check({tag, " tap_count"}, tap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < tap_q.size(); k++)
      check($sformatf("%s tap%0d", tag, k), tap_q[k], exp_q[k]);
`endif
  endtask

  typedef struct {
    logic [7:0]  c;
    int          n;
    logic [47:0] b;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    int          cnt;
    tbl[0] = '{8'h61, 3, 48'h1CF01C000000};
    tbl[1] = '{8'h41, 6, 48'h121CF01CF012};
    tbl[2] = '{8'h23, 0, 48'h0};
    tbl[3] = '{8'h30, 3, 48'h45F045000000};
    tbl[4] = '{8'h5A, 6, 48'h121AF01AF012};
    tbl[5] = '{8'h6D, 3, 48'h3AF03A000000};
    tbl[6] = '{8'h39, 3, 48'h46F046000000};
    tbl[7] = '{8'h35, 3, 48'h2EF02E000000};
    tbl[8] = '{8'h7E, 0, 48'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset ready/busy/unsup", {ascii_ready, busy, unsupported}, 3'b100);
    check("reset lines", {ps2_clk, ps2_data}, 2'b11);
`ifdef PS2TX_BYTE_TAP_EN
    check("reset tap", {tap_flag, tap_data}, 9'h0);
`endif
    @(negedge clk) rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      exp_q.delete();
      for (int k = 0; k < tbl[t].n; k++) exp_q.push_back(tbl[t].b[47 - 8 * k -: 8]);
      run_char(tbl[t].c, $sformatf("tbl%0d", t));
      if (t == 0) begin
        for (int i = 0; i < 11; i++) f[i] = (rx_bits.size() > i) ? rx_bits[i] : 1'b1;
        check("a frame0 bits", f, 11'b10000111000);
      end
    end

    for (int r = 0; r < 12; r++) begin
      logic [7:0] c;
      case ($urandom_range(0, 9))
        0, 1, 2: c = 8'h30 + 8'($urandom_range(0, 9));
        3, 4, 5: c = 8'h61 + 8'($urandom_range(0, 25));
        6, 7:    c = 8'h41 + 8'($urandom_range(0, 25));
        default: c = 8'($urandom_range(32, 126));
      endcase
      build_expected(c);
      run_char(c, $sformatf("rnd%0d_%0h", r, c));
    end

    // Back-to-back: 'c' presented while 'b' is in flight must wait for the whole 'b' sequence.
    rx_bits.delete();
    falls = 0;
    @(negedge clk);
    ascii_in = 8'h62;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1 ascii_in = 8'h63;
    check("b2b busy_after_first", busy, 1);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (ascii_ready !== 1'b1 && cnt < 3 * BYTE_CYC + 50);
    check("b2b falls_before_second", falls, 33);
    @(posedge clk);
    #1 ascii_valid = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 3 * BYTE_CYC + 50) begin cnt++; @(posedge clk); #1; end
    check("b2b second_busy", cnt, 3 * BYTE_CYC);
    exp_q = '{8'h32, 8'hF0, 8'h32, 8'h21, 8'hF0, 8'h21};
    check("b2b total_falls", falls, 66);
    check_frames("b2b");

    // Asynchronous reset during the data bit 3 high phase of the 'z' frame.
    rx_bits.delete();
    falls = 0;
    @(negedge clk);
    ascii_in = 8'h7A;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1 ascii_valid = 1'b0;
    cnt = 0;
    while (falls < 4 && cnt < 500) begin @(negedge clk); cnt++; end
    while (ps2_clk !== 1'b1 && cnt < 500) begin @(negedge clk); cnt++; end
    @(negedge clk);
    check("rst pre_falls", falls, 4);
    check("rst pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst async_lines", {ps2_clk, ps2_data}, 2'b11);
    check("rst async_busy", busy, 0);
    check("rst async_ready", ascii_ready, 1);
    #20 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("rst no_resume_falls", falls, 4);
    check("rst no_resume_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
